// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the two-master memory arbiter.
// Optional round-robin grant is selected by defining ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  // Wait counter only has to reach TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and load/store masters.
// ARB_ROUND_ROBIN_EN defined: alternate on contention; otherwise ls has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic clock,
  input  logic reset,
  input  logic take,
`endif
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_grant;

  // Remember who won the last accepted request so a contest goes to the other one.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= OWN_IF;
    end else if (take) begin
      last_grant <= grant_ls ? OWN_LS : OWN_IF;
    end
  end

  always_comb begin
    grant_ls = ls_valid && (!if_valid || (last_grant == OWN_IF));
    grant_if = if_valid && !grant_ls;
  end
`else
  always_comb begin
    grant_ls = ls_valid;
    grant_if = if_valid && !ls_valid;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Merges fetch and load/store masters onto one memory port, one transaction in flight.
// Grant policy: fixed ls priority by default, round-robin with ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_ren,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  input  logic                mem_hit,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                err_timeout
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] ls_data_q;
  logic              err_q;
  logic              grant_if, grant_ls;
  logic              accept, rd_hit, rd_retry, rd_expire;

  mem_arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
    .clock    (clock),
    .reset    (reset),
    .take     (accept),
`endif
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  assign accept    = !reset && (state_q == IDLE) && (grant_if || grant_ls);
  assign rd_hit    = mem_rvalid && mem_hit;
  assign rd_retry  = mem_rvalid && !mem_hit;
  assign rd_expire = !mem_rvalid && (cnt_q == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = wen_q ? RESP : WAIT;
      WAIT: begin
        if (rd_hit)         state_d = RESP;
        else if (rd_retry)  state_d = ISSUE;
        else if (rd_expire) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The wait counter is cleared only on accept, so a miss-retry keeps the elapsed time.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      cnt_q     <= '0;
      if_data_q <= '0;
      ls_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= grant_ls ? OWN_LS : OWN_IF;
            addr_q  <= grant_ls ? ls_req_addr : if_req_addr;
            wen_q   <= grant_ls && ls_req_wen;
            wdata_q <= grant_ls ? ls_req_wdata : '0;
            wmask_q <= grant_ls ? ls_req_wmask : '0;
            cnt_q   <= '0;
          end
        end
        ISSUE: begin
          if (wen_q) ls_data_q <= '0;
        end
        WAIT: begin
          if (rd_hit) begin
            if (owner_q == OWN_LS) ls_data_q <= mem_rdata;
            else                   if_data_q <= mem_rdata;
          end else if (rd_retry) begin
            cnt_q <= cnt_q;
          end else if (rd_expire) begin
            err_q <= 1'b1;
            if (owner_q == OWN_LS) ls_data_q <= '0;
            else                   if_data_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign if_req_ready  = !reset && (state_q == IDLE) && grant_if;
  assign ls_req_ready  = !reset && (state_q == IDLE) && grant_ls;
  assign if_resp_valid = (state_q == RESP) && (owner_q == OWN_IF);
  assign ls_resp_valid = (state_q == RESP) && (owner_q == OWN_LS);
  assign if_resp_data  = if_data_q;
  assign ls_resp_data  = ls_data_q;

  // Memory-side fields are forced to zero outside their strobe cycle.
  assign mem_ren     = (state_q == ISSUE) && !wen_q;
  assign mem_wen     = (state_q == ISSUE) && wen_q;
  assign mem_addr    = (state_q == ISSUE) ? addr_q : '0;
  assign mem_wdata   = mem_wen ? wdata_q : '0;
  assign mem_wmask   = mem_wen ? wmask_q : '0;
  assign err_timeout = err_q;

endmodule
